// File: rtl/alu_pkg.sv
// Shared definitions for the ALU request scheduler: opcode encodings, FSM
// states and the opcode-to-settling-time lookup.
package alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_DIV  = 3'b011;
    localparam logic [2:0] OP_MOD  = 3'b100;
    localparam logic [2:0] OP_SQ   = 3'b101;
    localparam logic [2:0] OP_CUBE = 3'b110;
    localparam logic [2:0] OP_ZERO = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Number of cycles the ALU inputs must stay stable for a given opcode.
    function automatic int lat_sel(input logic [2:0] op,
                                   input int lat_add,
                                   input int lat_mul,
                                   input int lat_cube,
                                   input int lat_div);
        case (op)
            OP_MUL, OP_SQ:  return lat_mul;
            OP_CUBE:        return lat_cube;
            OP_DIV, OP_MOD: return lat_div;
            default:        return lat_add;
        endcase
    endfunction

    function automatic logic is_divide(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_MOD);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. ptr=0 favours requester 0; after every grant
// the pointer moves to the requester that did not win.
module rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic valid0,
    input  logic valid1,
    output logic grant0,
    output logic grant1
);

    logic ptr;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (en) begin
            if (valid0 && valid1) begin
                grant0 = ~ptr;
                grant1 = ptr;
            end else begin
                grant0 = valid0;
                grant1 = valid1;
            end
        end
    end

    // A grant is only ever issued to a valid requester, so grant == accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= 1'b0;
        else if (grant0 || grant1)
            ptr <= grant0;
    end

endmodule

// File: rtl/alu_req_scheduler.sv
// Shares one combinational ALU between two requesters: grants one command at a
// time, holds the ALU inputs for the opcode's settling time, returns the result.
module alu_req_scheduler
    import alu_pkg::*;
#(
    parameter int W        = 32,
    parameter int LAT_ADD  = 1,
    parameter int LAT_MUL  = 2,
    parameter int LAT_CUBE = 4,
    parameter int LAT_DIV  = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [2:0]   req0_op,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [2:0]   req1_op,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    output logic [W-1:0] alu_var1,
    output logic [W-1:0] alu_var2,
    output logic [2:0]   alu_op,
    input  logic [W-1:0] alu_result,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_data,
    output logic         rsp_id,
    output logic         rsp_err,
    output logic         busy
);

    localparam int LAT_M1  = (LAT_ADD > LAT_MUL) ? LAT_ADD : LAT_MUL;
    localparam int LAT_M2  = (LAT_CUBE > LAT_DIV) ? LAT_CUBE : LAT_DIV;
    localparam int LAT_MAX = (LAT_M1 > LAT_M2) ? LAT_M1 : LAT_M2;
    localparam int CW      = $clog2(LAT_MAX) + 1;

    typedef logic [CW-1:0] cnt_t;

    state_t       state, state_nxt;
    logic         grant0, grant1;
    logic         idle, accept;
    logic [2:0]   sel_op;
    logic [W-1:0] sel_a, sel_b;
    logic         sel_divz;

    logic [2:0]   op_q;
    logic [W-1:0] a_q, b_q;
    logic         id_q;
    logic         divz_q;
    logic         zero_q;
    cnt_t         cnt;

    assign idle = (state == ST_IDLE);
    assign busy = ~idle;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .en     (idle),
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .grant0 (grant0),
        .grant1 (grant1)
    );

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

    assign sel_op   = grant1 ? req1_op : req0_op;
    assign sel_a    = grant1 ? req1_a  : req0_a;
    assign sel_b    = grant1 ? req1_b  : req0_b;
    // The ALU output is meaningless for a zero divisor; skip the wait entirely.
    assign sel_divz = is_divide(sel_op) && (sel_b == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        alu_var1  = '0;
        alu_var2  = '0;
        alu_op    = OP_ZERO;
        case (state)
            ST_IDLE: begin
                if (accept)
                    state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                alu_var1 = a_q;
                alu_var2 = b_q;
                alu_op   = op_q;
                if (cnt == cnt_t'(1))
                    state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Command capture, settle counter and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q      <= OP_ZERO;
            a_q       <= '0;
            b_q       <= '0;
            id_q      <= 1'b0;
            divz_q    <= 1'b0;
            zero_q    <= 1'b0;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q   <= sel_op;
                        a_q    <= sel_a;
                        b_q    <= sel_b;
                        id_q   <= grant1;
                        divz_q <= sel_divz;
                        zero_q <= sel_divz || (sel_op == OP_ZERO);
                        cnt    <= sel_divz ? cnt_t'(1)
                                           : cnt_t'(lat_sel(sel_op, LAT_ADD, LAT_MUL,
                                                            LAT_CUBE, LAT_DIV));
                    end
                end
                ST_EXEC: begin
                    if (cnt == cnt_t'(1)) begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= zero_q ? '0 : alu_result;
                        rsp_id    <= id_q;
                        rsp_err   <= divz_q;
                    end else begin
                        cnt <= cnt - cnt_t'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_ready)
                        rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Directed bench for alu_req_scheduler with a behavioural ALU on the far side.
module tb_alu_req_scheduler;

    localparam int W = 32;

    logic         clk, rst;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [2:0]   req0_op, req1_op, alu_op;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [W-1:0] alu_var1, alu_var2, alu_result, rsp_data;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_err, busy;

    int n_chk  = 0;
    int n_fail = 0;

    alu_req_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .alu_var1   (alu_var1),
        .alu_var2   (alu_var2),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The shared combinational ALU; a zero divisor yields junk on purpose.
    always_comb begin
        case (alu_op)
            3'b000:  alu_result = alu_var1 + alu_var2;
            3'b001:  alu_result = alu_var1 - alu_var2;
            3'b010:  alu_result = alu_var1 * alu_var2;
            3'b011:  alu_result = (alu_var2 != 0) ? alu_var1 / alu_var2 : 32'hDEAD_BEEF;
            3'b100:  alu_result = (alu_var2 != 0) ? alu_var1 % alu_var2 : 32'hDEAD_BEEF;
            3'b101:  alu_result = alu_var1 * alu_var1;
            3'b110:  alu_result = alu_var1 * alu_var1 * alu_var1;
            default: alu_result = '0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Count edges after the accept edge until rsp_valid is seen (bounded).
    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic consume(input string tag);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, "_rsp_valid_clr"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    // Single requester issues one command; checks grant, latency and response.
    task automatic run_op(input string tag, input logic id, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input int exp_lat, input logic [31:0] exp_data, input logic exp_err);
        int lat;
        if (id) begin
            req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1;
        end else begin
            req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1;
        end
        #1;
        chk({tag, "_ready"}, 32'(id ? req1_ready : req0_ready), 32'd1);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_rsp(lat);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_data"}, rsp_data, exp_data);
        chk({tag, "_id"}, 32'(rsp_id), 32'(id));
        chk({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
        consume(tag);
    endtask

    initial begin
        int lat;
        rst = 1'b1; rsp_ready = 1'b0;
        req0_valid = 1'b0; req0_op = 3'b000; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_op = 3'b000; req1_a = '0; req1_b = '0;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd7);
        chk("rst_rsp_data", rsp_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // T1: reset while a divide is in flight
        req0_op = 3'b011; req0_a = 32'd100; req0_b = 32'd7; req0_valid = 1'b1;
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        chk("t1_busy_exec", 32'(busy), 32'd1);
        chk("t1_alu_op_held", 32'(alu_op), 32'd3);
        chk("t1_alu_var1", alu_var1, 32'd100);
        chk("t1_alu_var2", alu_var2, 32'd7);
        rst = 1'b1;
        #1;
        chk("t1_busy_rst", 32'(busy), 32'd0);
        chk("t1_rsp_valid_rst", 32'(rsp_valid), 32'd0);
        chk("t1_alu_op_rst", 32'(alu_op), 32'd7);
        chk("t1_alu_var1_rst", alu_var1, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("t1_no_phantom", 32'(rsp_valid), 32'd0);

        // T2: add, also watch the ALU drive during EXEC
        req0_op = 3'b000; req0_a = 32'd5; req0_b = 32'd7; req0_valid = 1'b1;
        #1;
        chk("t2_ready0", 32'(req0_ready), 32'd1);
        @(negedge clk);
        req0_valid = 1'b0;
        chk("t2_alu_op", 32'(alu_op), 32'd0);
        chk("t2_alu_var2", alu_var2, 32'd7);
        wait_rsp(lat);
        chk("t2_lat", 32'(lat), 32'd1);
        chk("t2_data", rsp_data, 32'd12);
        chk("t2_id", 32'(rsp_id), 32'd0);
        chk("t2_err", 32'(rsp_err), 32'd0);
        chk("t2_alu_quiet", 32'(alu_op), 32'd7);
        consume("t2");

        // T4: divide by zero on requester 1 (pointer now favours requester 1)
        run_op("t4", 1'b1, 3'b011, 32'd10, 32'd0, 1, 32'd0, 1'b1);

        // T3: contention, grants 0,1,0
        req0_op = 3'b010; req0_a = 32'd3; req0_b = 32'd4; req0_valid = 1'b1;
        req1_op = 3'b001; req1_a = 32'd9; req1_b = 32'd2; req1_valid = 1'b1;
        #1;
        chk("t3_g1_ready0", 32'(req0_ready), 32'd1);
        chk("t3_g1_ready1", 32'(req1_ready), 32'd0);
        @(negedge clk);
        req0_valid = 1'b0;
        chk("t3_exec_ready1", 32'(req1_ready), 32'd0);
        wait_rsp(lat);
        chk("t3_g1_lat", 32'(lat), 32'd2);
        chk("t3_g1_data", rsp_data, 32'd12);
        chk("t3_g1_id", 32'(rsp_id), 32'd0);
        chk("t3_resp_ready1", 32'(req1_ready), 32'd0);
        consume("t3_g1");
        chk("t3_g2_ready1", 32'(req1_ready), 32'd1);
        @(negedge clk);
        req0_op = 3'b000; req0_a = 32'd1; req0_b = 32'd1; req0_valid = 1'b1;
        wait_rsp(lat);
        chk("t3_g2_lat", 32'(lat), 32'd1);
        chk("t3_g2_data", rsp_data, 32'd7);
        chk("t3_g2_id", 32'(rsp_id), 32'd1);
        consume("t3_g2");
        chk("t3_g3_ready0", 32'(req0_ready), 32'd1);
        chk("t3_g3_ready1", 32'(req1_ready), 32'd0);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_rsp(lat);
        chk("t3_g3_data", rsp_data, 32'd2);
        chk("t3_g3_id", 32'(rsp_id), 32'd0);
        consume("t3_g3");

        // T5: cube under backpressure, with a new command waiting
        req0_op = 3'b110; req0_a = 32'd3; req0_b = 32'd0; req0_valid = 1'b1;
        @(negedge clk);
        req0_valid = 1'b0;
        wait_rsp(lat);
        chk("t5_lat", 32'(lat), 32'd4);
        req0_op = 3'b000; req0_a = 32'd2; req0_b = 32'd2; req0_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t5_hold_valid", 32'(rsp_valid), 32'd1);
            chk("t5_hold_data", rsp_data, 32'd27);
            chk("t5_hold_ready0", 32'(req0_ready), 32'd0);
            @(negedge clk);
        end
        consume("t5");
        chk("t5_ready_after", 32'(req0_ready), 32'd1);
        req0_valid = 1'b0;
        @(negedge clk);
        chk("t5_no_accept", 32'(busy), 32'd0);

        // T6: long-latency divide and modulo, plus remaining opcodes
        run_op("t6_div", 1'b0, 3'b011, 32'd100, 32'd7, 6, 32'd14, 1'b0);
        run_op("t6_mod", 1'b0, 3'b100, 32'd100, 32'd7, 6, 32'd2, 1'b0);
        run_op("t6_modz", 1'b0, 3'b100, 32'd9, 32'd0, 1, 32'd0, 1'b1);
        run_op("t6_sq", 1'b1, 3'b101, 32'd5, 32'd0, 2, 32'd25, 1'b0);
        run_op("t6_zero", 1'b1, 3'b111, 32'd8, 32'd9, 1, 32'd0, 1'b0);
        run_op("t6_subwrap", 1'b0, 3'b001, 32'd2, 32'd3, 1, 32'hFFFF_FFFF, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
